// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: shared bus codes, request sizes, master states and request helpers
package cpu_bus_pkg;
  localparam logic [1:0] RD32 = 2'b00;
  localparam logic [1:0] WR8 = 2'b01;
  localparam logic [1:0] WR16 = 2'b10;
  localparam logic [1:0] WR32 = 2'b11;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_ILL = 2'b11;
  localparam int TIMEOUT_DEFAULT = 16;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE, RESP} state_t;
  function automatic logic bad_req(input logic [1:0] sz, input logic [1:0] a);
    return sz == SZ_ILL || (sz == SZ_H && a[0]) || (sz == SZ_W && a != 2'b00);
  endfunction
  function automatic logic [1:0] wlen_of(input logic we, input logic [1:0] sz);
    return !we ? RD32 : sz == SZ_B ? WR8 : sz == SZ_H ? WR16 : WR32;
  endfunction
endpackage

// File: rtl/cpu_load_align.sv
// cpu_load_align: picks the addressed byte/half from responder data and extends it
module cpu_load_align
  import cpu_bus_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic        addr0,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] data
);
  logic [7:0] b;
  assign b = addr0 ? rdata[15:8] : rdata[7:0];
  assign data = size == SZ_B ? {{24{~uns & b[7]}}, b} :
                size == SZ_H ? {{16{~uns & rdata[15]}}, rdata[15:0]} : rdata;
endmodule

// File: rtl/cpu_bus_master.sv
// cpu_bus_master: turns one CPU load/store into a single timed cpu_bus transaction
module cpu_bus_master
  import cpu_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] address,
  output logic [31:0]       wdata,
  output logic [1:0]        WLEN,
  output logic              EN_N,
  input  logic              READY,
  input  logic [31:0]       rdata
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  state_t state;
  logic we, uns, tmo;
  logic [1:0] size;
  logic [CW-1:0] cnt;
  logic [31:0] ld;
  cpu_load_align u_align (.rdata(rdata), .addr0(address[0]), .size(size), .uns(uns), .data(ld));
  assign req_ready = state == IDLE;
  assign EN_N = state != ISSUE;
  assign tmo = cnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      address <= '0;
      wdata <= '0;
      WLEN <= RD32;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err <= 1'b0;
      cnt <= '0;
      we <= 1'b0;
      uns <= 1'b0;
      size <= SZ_B;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          we <= req_we;
          size <= req_size;
          uns <= req_unsigned;
          if (bad_req(req_size, req_addr[1:0])) begin
            state <= RESP;
            resp_valid <= 1'b1;
            resp_err <= 1'b1;
            resp_rdata <= '0;
          end else begin
            address <= req_addr;
            wdata <= req_wdata;
            WLEN <= wlen_of(req_we, req_size);
            cnt <= '0;
            state <= ISSUE;
          end
        end
        ISSUE: state <= READY ? WAIT_ACK : ISSUE;
        WAIT_ACK: begin
          cnt <= cnt + 1'b1;
          if (tmo) begin
            state <= RESP;
            resp_valid <= 1'b1;
            resp_err <= 1'b1;
            resp_rdata <= '0;
          end else if (!READY) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          cnt <= cnt + 1'b1;
          if (READY || tmo) begin
            state <= RESP;
            resp_valid <= 1'b1;
            resp_err <= !READY;
            resp_rdata <= READY && !we ? ld : '0;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_bus_master.sv
// tb_cpu_bus_master: table, random and corner-case checks against a responder model
module tb_cpu_bus_master;
  logic clk = 1'b0, reset = 1'b1;
  logic req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0] req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0, rdata = '0;
  logic req_ready, resp_valid, resp_err, EN_N;
  logic [31:0] resp_rdata, address, wdata;
  logic [1:0] WLEN;
  logic READY = 1'b1;
  int n_vec = 0, n_err = 0;
  int busy = 0, extra = 0, n_txn = 0, en_low = 0;
  logic hold = 1'b0;
  logic [31:0] cap_addr = '0, cap_wdata = '0;
  logic [1:0] cap_wlen = '0;
  always #5 clk = ~clk;
  cpu_bus_master dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .address(address),
    .wdata(wdata), .WLEN(WLEN), .EN_N(EN_N), .READY(READY), .rdata(rdata)
  );
  always @(posedge clk) begin
    if (!EN_N) en_low <= en_low + 1;
    if (busy > 0) begin
      busy <= busy - 1;
      if (busy == 1) READY <= 1'b1;
    end else if (!EN_N && READY) begin
      n_txn <= n_txn + 1;
      cap_addr <= address;
      cap_wdata <= wdata;
      cap_wlen <= WLEN;
      if (!hold) begin
        READY <= 1'b0;
        busy <= (WLEN == 2'b10 ? 1 : 2) + extra;
      end
    end
  end
  typedef struct {
    logic we; logic [1:0] size; logic uns;
    logic [31:0] addr, wd, rd, exp_rdata; logic exp_err; int exp_lat;
  } vec_t;
  vec_t tbl[12];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic start_req(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask
  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_valid && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask
  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns,
                                           input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    v = rd >> (8 * int'(a[0]));
    if (sz == 2'd0) return uns ? 32'(v[7:0]) : 32'($signed(v[7:0]));
    if (sz == 2'd1) return uns ? 32'(rd[15:0]) : 32'($signed(rd[15:0]));
    return rd;
  endfunction
  task automatic run(input vec_t v);
    int lat, t0, e0;
    logic [1:0] ew;
    ew = v.we ? 2'(v.size + 2'd1) : 2'b00;
    rdata = v.rd;
    t0 = n_txn; e0 = en_low;
    start_req(v.we, v.size, v.uns, v.addr, v.wd);
    wait_resp(lat);
    chk("latency", 32'(lat), 32'(v.exp_lat));
    chk("resp_rdata", resp_rdata, v.exp_rdata);
    chk("resp_err", 32'(resp_err), 32'(v.exp_err));
    @(posedge clk);
    #1 chk("resp_pulse", 32'(resp_valid), 32'd0);
    chk("resp_hold", resp_rdata, v.exp_rdata);
    chk("bus_txns", 32'(n_txn - t0), v.exp_err ? 32'd0 : 32'd1);
    chk("en_cycles", 32'(en_low - e0), v.exp_err ? 32'd0 : 32'd1);
    if (!v.exp_err) begin
      chk("bus_addr", cap_addr, v.addr);
      chk("bus_wlen", 32'(cap_wlen), 32'(ew));
      if (v.we) chk("bus_wdata", cap_wdata, v.wd);
    end
  endtask
  initial begin
    int lat;
    vec_t r;
    tbl[0]  = '{0, 2'd2, 0, 32'h100, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 5};
    tbl[1]  = '{0, 2'd0, 0, 32'h101, 32'h0, 32'h00008000, 32'hFFFFFF80, 0, 5};
    tbl[2]  = '{0, 2'd0, 1, 32'h101, 32'h0, 32'h00008000, 32'h00000080, 0, 5};
    tbl[3]  = '{1, 2'd1, 0, 32'h80000, 32'h1234, 32'h0, 32'h0, 0, 4};
    tbl[4]  = '{0, 2'd2, 0, 32'h102, 32'h0, 32'h11111111, 32'h0, 1, 1};
    tbl[5]  = '{0, 2'd1, 0, 32'h202, 32'h0, 32'h00008001, 32'hFFFF8001, 0, 5};
    tbl[6]  = '{1, 2'd0, 0, 32'h203, 32'hA5, 32'h0, 32'h0, 0, 5};
    tbl[7]  = '{0, 2'd1, 1, 32'h203, 32'h0, 32'h12345678, 32'h0, 1, 1};
    tbl[8]  = '{0, 2'd3, 0, 32'h0, 32'h0, 32'h12345678, 32'h0, 1, 1};
    tbl[9]  = '{1, 2'd2, 0, 32'h40, 32'hCAFEF00D, 32'h0, 32'h0, 0, 5};
    tbl[10] = '{0, 2'd0, 1, 32'h200, 32'h0, 32'h000012AB, 32'h000000AB, 0, 5};
    tbl[11] = '{0, 2'd1, 1, 32'h10, 32'h0, 32'hFFFF9876, 32'h00009876, 0, 5};
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_en_n", 32'(EN_N), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_address", address, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_wlen", 32'(WLEN), 32'd0);
    foreach (tbl[i]) run(tbl[i]);
    for (int i = 0; i < 60; i++) begin
      r.we = 1'($urandom); r.size = 2'($urandom_range(0, 3)); r.uns = 1'($urandom);
      r.addr = $urandom; r.wd = $urandom; r.rd = $urandom;
      r.exp_err = r.size == 2'd3 || (r.size == 2'd1 && r.addr[0]) || (r.size == 2'd2 && r.addr[1:0] != 0);
      r.exp_rdata = r.exp_err || r.we ? 32'h0 : ref_load(r.size, r.uns, r.addr, r.rd);
      r.exp_lat = r.exp_err ? 1 : (r.we && r.size == 2'd1) ? 4 : 5;
      run(r);
    end
    hold = 1'b1;
    start_req(1'b0, 2'd2, 1'b0, 32'h300, 32'h0);
    wait_resp(lat);
    chk("timeout_lat", 32'(lat), 32'd18);
    chk("timeout_err", 32'(resp_err), 32'd1);
    chk("timeout_rdata", resp_rdata, 32'd0);
    @(posedge clk);
    #1 chk("timeout_idle", 32'(req_ready), 32'd1);
    hold = 1'b0;
    extra = 6;
    start_req(1'b0, 2'd2, 1'b0, 32'h400, 32'h0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_mid_en_n", 32'(EN_N), 32'd1);
    chk("rst_mid_idle", 32'(req_ready), 32'd1);
    chk("rst_mid_no_resp", 32'(resp_valid), 32'd0);
    extra = 0;
    start_req(1'b1, 2'd0, 1'b0, 32'h301, 32'h000000A5);
    chk("sb_waits_issue", 32'(EN_N), 32'd0);
    chk("sb_ready_low", 32'(READY), 32'd0);
    wait_resp(lat);
    chk("sb_resp", 32'(resp_valid), 32'd1);
    chk("sb_err", 32'(resp_err), 32'd0);
    chk("sb_rdata", resp_rdata, 32'd0);
    chk("sb_addr", cap_addr, 32'h301);
    chk("sb_wlen", 32'(cap_wlen), 32'd1);
    chk("sb_wdata", cap_wdata, 32'hA5);
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
